// File: rtl/sc_game_pkg.sv
// Shared definitions for the RoadFighter front-panel key logic.
package sc_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DEBOUNCE_1MS_50MHZ = 50000;

endpackage

// File: rtl/sc_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sc_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      sync_1 <= d;
      q      <= sync_1;
    end
  end

endmodule

// File: rtl/sc_button_pulse_gen.sv
// Debounces an active-low pushbutton and emits one active-high pulse per accepted press.
module sc_button_pulse_gen
  import sc_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic sc_button_pulse_gen_CLOCK_50,
  input  logic sc_button_pulse_gen_RESET_InHigh,
  input  logic sc_button_pulse_gen_button_InLow,
  output logic sc_button_pulse_gen_pulse_Out,
  output logic sc_button_pulse_gen_level_Out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             clk;
  logic             rst;
  logic             sync_2;
  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse, pulse_nxt;
  logic             level, level_nxt;

  assign clk = sc_button_pulse_gen_CLOCK_50;
  assign rst = sc_button_pulse_gen_RESET_InHigh;

  // Resets to released so a reset never looks like a press edge.
  sc_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sc_button_pulse_gen_button_InLow),
    .q   (sync_2)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    level_nxt = level;
    unique case (state)
      ST_IDLE: begin
        if (!sync_2) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        // A bounce sample wins over a terminal count on the same edge.
        if (sync_2) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_PRESSED;
          pulse_nxt = 1'b1;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (sync_2) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync_2) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_IDLE;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
      level <= level_nxt;
    end
  end

  assign sc_button_pulse_gen_pulse_Out = pulse;
  assign sc_button_pulse_gen_level_Out = level;

endmodule
